// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control FSM for the 16-bit
// Harvard core. Owns the PC, issues one-hot phase strobes, resolves JMP/BEQZ
// and supports free-run, single-step and a sticky HALT state.
// Optional build macro SEQ_PERF_CNT_EN adds retired_cnt and cycle_cnt.
module cpu_sequencer #(
  parameter int PC_W     = 7,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic [31:0]     instr,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            decode_en,
  output logic            exec_en,
  output logic            wb_en,
  output logic            reg_write_en,
  output logic            busy,
  output logic            halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]     retired_cnt,
  output logic [15:0]     cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  // Only the opcode nibble and the branch target of the instruction matter.
  logic [3:0]        ir_op_q, ir_op_d;
  logic [PC_W-1:0]   ir_tgt_q, ir_tgt_d;
  logic              zero_q, zero_d;

  // Middle instruction bits carry ALU fields consumed elsewhere in the core.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[27:PC_W];

  function automatic logic op_is_halt(input logic [3:0] op);
    return (op == 4'hF);
  endfunction

  function automatic logic op_is_beqz(input logic [3:0] op);
    return (op == 4'hE);
  endfunction

  function automatic logic op_is_jmp(input logic [3:0] op);
    return (op == 4'hD);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: run dominates step, HALT is sticky, WB chains under run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end else if (step) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (op_is_halt(ir_op_q)) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: IR latched leaving FETCH, zero leaving EXEC, PC leaving WB.
  always_comb begin
    ir_op_d  = ir_op_q;
    ir_tgt_d = ir_tgt_q;
    zero_d   = zero_q;
    pc_d     = pc_q;
    if (state_q == ST_FETCH) begin
      ir_op_d  = instr[31:28];
      ir_tgt_d = instr[PC_W-1:0];
    end else begin
      ir_op_d  = ir_op_q;
      ir_tgt_d = ir_tgt_q;
    end
    if (state_q == ST_EXEC) begin
      zero_d = zero;
    end else begin
      zero_d = zero_q;
    end
    if (state_q == ST_WB) begin
      if (op_is_jmp(ir_op_q)) begin
        pc_d = ir_tgt_q;
      end else if (op_is_beqz(ir_op_q) && zero_q) begin
        pc_d = ir_tgt_q;
      end else begin
        pc_d = pc_q + PC_W'(PC_STEP);
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= PC_W'(RESET_PC);
      ir_op_q  <= 4'h0;
      ir_tgt_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_op_q  <= ir_op_d;
      ir_tgt_q <= ir_tgt_d;
      zero_q   <= zero_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    fetch_en     = (state_q == ST_FETCH);
    decode_en    = (state_q == ST_DECODE);
    exec_en      = (state_q == ST_EXEC);
    wb_en        = (state_q == ST_WB);
    reg_write_en = (state_q == ST_WB) && !op_is_jmp(ir_op_q) && !op_is_beqz(ir_op_q);
    busy         = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                   (state_q == ST_EXEC)  || (state_q == ST_WB);
    halted       = (state_q == ST_HALT);
  end

  assign pc = pc_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] cycles_q, cycles_d;

  // Counter next values: retire on each WB exit, count every busy cycle.
  always_comb begin
    retired_d = retired_q;
    cycles_d  = cycles_q;
    if (state_q == ST_WB) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
    if (busy) begin
      cycles_d = cycles_q + 16'd1;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 16'd0;
      cycles_q  <= 16'd0;
    end else begin
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycles_q;
`endif

endmodule
